// File: rtl/mem_access_pkg.sv
// Shared ISA opcode constants and mem_access FSM encoding.
package mem_access_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline handshake between alu (master) and the mem_access stage (slave).
interface mem_access_if #(parameter int DATA_W = 32);
    logic              valid_in;
    logic [3:0]        opcode_in;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        Regdst_in;
    logic [DATA_W-1:0] read_data2_in;
    logic              stall_out;
    logic              valid_out;
    logic [3:0]        opcode_out;
    logic [3:0]        Regdst_out;
    logic [DATA_W-1:0] mem_result_out;

    modport master (
        output valid_in, opcode_in, alu_out, Regdst_in, read_data2_in,
        input  stall_out, valid_out, opcode_out, Regdst_out, mem_result_out
    );

    modport slave (
        input  valid_in, opcode_in, alu_out, Regdst_in, read_data2_in,
        output stall_out, valid_out, opcode_out, Regdst_out, mem_result_out
    );
endinterface

// File: rtl/mem_access_dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read. Contents are not reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mem_access.sv
// Data-memory pipeline stage; DMEM_PRELOAD_EN adds a preload write port that wins over STOREs.
// state | meaning:  IDLE accept op | BUSY access in flight, stall upstream | DONE result pulse
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.slave       bus
`ifdef DMEM_PRELOAD_EN
    ,
    input  logic              mem_load,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [DATA_W-1:0] mem_write_data
`endif
);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [3:0]        regdst_q, regdst_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;

    logic              preload_hit;
    logic              pipe_we;
    logic [DATA_W-1:0] pipe_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

`ifdef DMEM_PRELOAD_EN
    assign preload_hit = mem_load;
    assign ram_waddr   = mem_load ? mem_write_addr : ram_addr;
    assign ram_wdata   = mem_load ? mem_write_data : pipe_wdata;
`else
    assign preload_hit = 1'b0;
    assign ram_waddr   = ram_addr;
    assign ram_wdata   = pipe_wdata;
`endif

    // Reset kills a pipeline write, but preload is still honoured during reset.
    assign ram_we = preload_hit | (pipe_we & ~rst);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        opcode_d   = opcode_q;
        regdst_d   = regdst_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        pipe_we    = 1'b0;
        pipe_wdata = data_q;
        ram_addr   = addr_q;
        case (state_q)
            ST_IDLE: begin
                ram_addr   = bus.alu_out[ADDR_W-1:0];
                pipe_wdata = bus.read_data2_in;
                if (bus.valid_in) begin
                    opcode_d = bus.opcode_in;
                    regdst_d = bus.Regdst_in;
                    addr_d   = bus.alu_out[ADDR_W-1:0];
                    data_d   = bus.read_data2_in;
                    if (!is_mem_op(bus.opcode_in)) begin
                        result_d = bus.alu_out;
                        valid_d  = 1'b1;
                    end else if (LATENCY == 1) begin
                        if (bus.opcode_in == OP_LOAD) begin
                            result_d = ram_rdata;
                            valid_d  = 1'b1;
                        end else if (preload_hit) begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            pipe_we  = 1'b1;
                            result_d = bus.read_data2_in;
                            valid_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    // A colliding preload defers the STORE; counter stays at 1 to retry.
                    if (!(opcode_q == OP_STORE && preload_hit)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        if (opcode_q == OP_STORE) begin
                            pipe_we  = 1'b1;
                            result_d = data_q;
                        end else begin
                            result_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            opcode_q <= '0;
            regdst_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            opcode_q <= opcode_d;
            regdst_q <= regdst_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_addr),
        .rdata (ram_rdata)
    );

    assign bus.stall_out      = (state_q == ST_BUSY);
    assign bus.valid_out      = valid_q;
    assign bus.opcode_out     = opcode_q;
    assign bus.Regdst_out     = regdst_q;
    assign bus.mem_result_out = result_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access (ADDR_W=8, DATA_W=32, LATENCY=2); preload case under DMEM_PRELOAD_EN.
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(32)) bus ();

`ifdef DMEM_PRELOAD_EN
    logic        mem_load = 1'b0;
    logic [7:0]  mem_write_addr = '0;
    logic [31:0] mem_write_data = '0;
`endif

    mem_access #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_PRELOAD_EN
        ,
        .mem_load       (mem_load),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [logic [7:0]];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("opcode_out", {28'd0, bus.opcode_out}, {28'd0, e.op});
                chk("Regdst_out", {28'd0, bus.Regdst_out}, {28'd0, e.rd});
                chk("mem_result_out", bus.mem_result_out, e.res);
            end
        end
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] alu,
                                   input logic [3:0] rd, input logic [31:0] wd);
        exp_t e;
        e.op = op;
        e.rd = rd;
        if (op == OP_STORE) begin
            mem_m[alu[7:0]] = wd;
            e.res = wd;
        end else if (op == OP_LOAD) begin
            e.res = mem_m.exists(alu[7:0]) ? mem_m[alu[7:0]] : 32'd0;
        end else begin
            e.res = alu;
        end
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] alu,
                         input logic [3:0] rd, input logic [31:0] wd);
        bus.valid_in      = 1'b1;
        bus.opcode_in     = op;
        bus.alu_out       = alu;
        bus.Regdst_in     = rd;
        bus.read_data2_in = wd;
        @(negedge clk);
        bus.valid_in      = 1'b0;
    endtask

    task automatic wait_done(output int stalls);
        int n = 0;
        stalls = 0;
        while (!bus.valid_out && n < 20) begin
            if (bus.stall_out) stalls++;
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] alu,
                        input logic [3:0] rd, input logic [31:0] wd, output int stalls);
        exp_q.push_back(model(op, alu, rd, wd));
        drive(op, alu, rd, wd);
        wait_done(stalls);
    endtask

    initial begin
        int st;
        bus.valid_in      = 1'b0;
        bus.opcode_in     = '0;
        bus.alu_out       = '0;
        bus.Regdst_in     = '0;
        bus.read_data2_in = '0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_valid",  {31'd0, bus.valid_out}, 32'd0);
        chk("rst_stall",  {31'd0, bus.stall_out}, 32'd0);
        chk("rst_opcode", {28'd0, bus.opcode_out}, 32'd0);
        chk("rst_regdst", {28'd0, bus.Regdst_out}, 32'd0);
        chk("rst_result", bus.mem_result_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pass-through ops
        send(OP_ADD, 32'h5, 4'd3, 32'h0, st);
        chk("pass_stalls", st, 0);
        send(OP_SUB, 32'hFFFF_0001, 4'd9, 32'h1234, st);
        send(OP_NOP, 32'h0000_00AA, 4'd0, 32'h0, st);

        // Store then load same address
        send(OP_STORE, 32'h10, 4'd1, 32'hDEADBEEF, st);
        chk("store_stalls", st, 1);
        send(OP_LOAD, 32'h10, 4'd4, 32'h0, st);
        chk("load_stalls", st, 1);

        // Address wrap
        send(OP_STORE, 32'h105, 4'd2, 32'd7, st);
        send(OP_LOAD, 32'h5, 4'd6, 32'h0, st);

        // Randomised stores then loads on a small address window
        for (int i = 0; i < 6; i++)
            send(OP_STORE, 32'h40 + i, 4'(i), $urandom, st);
        for (int i = 0; i < 6; i++)
            send(OP_LOAD, 32'h40 + $urandom_range(0, 5), 4'($urandom_range(0, 15)), 32'h0, st);
        send(OP_ADD, $urandom, 4'd7, 32'h0, st);

        // Reset mid-access: STORE must be abandoned
        send(OP_STORE, 32'h20, 4'd1, 32'd0, st);
        drive(OP_STORE, 32'h20, 4'd1, 32'd9);
        chk("busy_stall", {31'd0, bus.stall_out}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("midrst_stall", {31'd0, bus.stall_out}, 32'd0);
        chk("midrst_result", bus.mem_result_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(OP_LOAD, 32'h20, 4'd5, 32'h0, st);

`ifdef DMEM_PRELOAD_EN
        // Preload colliding with a completing STORE
        exp_q.push_back(model(OP_STORE, 32'h31, 4'd2, 32'd2));
        drive(OP_STORE, 32'h31, 4'd2, 32'd2);
        mem_load       = 1'b1;
        mem_write_addr = 8'h30;
        mem_write_data = 32'd1;
        mem_m[8'h30]   = 32'd1;
        chk("conflict_stall0", {31'd0, bus.stall_out}, 32'd1);
        @(negedge clk);
        mem_load = 1'b0;
        chk("conflict_stall1", {31'd0, bus.stall_out}, 32'd1);
        wait_done(st);
        send(OP_LOAD, 32'h30, 4'd8, 32'h0, st);
        send(OP_LOAD, 32'h31, 4'd9, 32'h0, st);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
